// File: rtl/uart_rx_deserializer_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry,
// common to the RX deserializer, TX serializer and baud generator.
package uart_rx_deserializer_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } rx_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets the value both flops take while in reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front-end: oversampled start/data/parity/stop deserializer
// feeding the RX FIFO write port directly.
module uart_rx_deserializer
    import uart_rx_deserializer_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err
);

    localparam int TW = $clog2(max_int(OVERSAMPLE, SB_TICKS));
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_TICK  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_TICK = TW'(SB_TICKS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    logic                 rx_s;
    rx_state_t            state_q,   state_d;
    logic [TW-1:0]        tick_q,    tick_d;
    logic [BW-1:0]        bit_q,     bit_d;
    logic [DATA_BITS-1:0] shreg_q,   shreg_d;
    logic                 par_bad_q, par_bad_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 done_q,    done_d;
    logic                 ferr_q,    ferr_d;
    logic                 perr_q,    perr_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_rx),
        .o_q       (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_q == MID_TICK) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK) begin
                        tick_d  = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK) begin
                        tick_d    = '0;
                        par_bad_d = (^shreg_q) ^ rx_s ^ ODD;
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_q == STOP_TICK) begin
                        tick_d  = '0;
                        state_d = ST_IDLE;
                        // Framing error masks any parity result.
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                        end else if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            data_d = shreg_q;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_data       = data_q;
    assign o_rx_done    = done_q;
    assign o_frame_err  = ferr_q;
    assign o_parity_err = perr_q;

endmodule
